apb_to_ahbl: RTL and testbench

APB_TO_AHBL -- requirements
Module: apb_to_ahbl

---
 rtl/apb_to_ahbl.sv | 141 ++++++++++++++
 tb/tb_apb_to_ahbl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_ahbl.sv
// APB requester to AHB-Lite manager bridge: each APB access becomes one AHB-Lite SINGLE transfer.
// Optional byte/halfword writes via APB strobes when APB_TO_AHBL_PSTRB_EN is defined.
module apb_to_ahbl #(
  parameter int         W_ADDR    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apbs_psel,
  input  logic              apbs_penable,
  input  logic              apbs_pwrite,
  input  logic [W_ADDR-1:0] apbs_paddr,
  input  logic [31:0]       apbs_pwdata,
`ifdef APB_TO_AHBL_PSTRB_EN
  input  logic [3:0]        apbs_pstrb,
`endif
  output logic [31:0]       apbs_prdata,
  output logic              apbs_pready,
  output logic              apbs_pslverr,
  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [2:0]        ahblm_hburst,
  output logic [3:0]        ahblm_hprot,
  output logic              ahblm_hmastlock,
  input  logic              ahblm_hready,
  input  logic              ahblm_hresp,
  input  logic [31:0]       ahblm_hrdata,
  output logic [31:0]       ahblm_hwdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              err_q, err_d;

  logic [2:0] req_size;
  logic [1:0] req_lane;
  logic       strb_ok;

  // Strobe decode: picks transfer size and byte lane; unsupported write patterns are rejected.
  always_comb begin
    req_size = 3'b010;
    req_lane = 2'b00;
    strb_ok  = 1'b1;
`ifdef APB_TO_AHBL_PSTRB_EN
    if (apbs_pwrite) begin
      case (apbs_pstrb)
        4'b0001: begin req_size = 3'b000; req_lane = 2'd0; end
        4'b0010: begin req_size = 3'b000; req_lane = 2'd1; end
        4'b0100: begin req_size = 3'b000; req_lane = 2'd2; end
        4'b1000: begin req_size = 3'b000; req_lane = 2'd3; end
        4'b0011: begin req_size = 3'b001; req_lane = 2'd0; end
        4'b1100: begin req_size = 3'b001; req_lane = 2'd2; end
        4'b1111: begin req_size = 3'b010; req_lane = 2'd0; end
        default: strb_ok = 1'b0;
      endcase
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (apbs_psel && apbs_penable) begin
          addr_d  = {apbs_paddr[W_ADDR-1:2], req_lane};
          write_d = apbs_pwrite;
          wdata_d = apbs_pwdata;
          size_d  = req_size;
          if (strb_ok) begin
            state_d = S_ADDR;
          end else begin
            err_d    = 1'b1;
            prdata_d = 32'h0;
            state_d  = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (ahblm_hready) state_d = S_DATA;
      end
      S_DATA: begin
        if (ahblm_hready) begin
          err_d    = ahblm_hresp;
          prdata_d = write_q ? 32'h0 : ahblm_hrdata;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
      size_q   <= 3'b010;
      prdata_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  // The bridge issues only NONSEQ or IDLE; the data phase always shows IDLE.
  assign ahblm_htrans    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign ahblm_haddr     = addr_q;
  assign ahblm_hwrite    = write_q;
  assign ahblm_hsize     = size_q;
  assign ahblm_hwdata    = wdata_q;
  assign ahblm_hburst    = 3'b000;
  assign ahblm_hprot     = HPROT_VAL;
  assign ahblm_hmastlock = 1'b0;

  assign apbs_pready  = (state_q == S_RESP);
  assign apbs_pslverr = (state_q == S_RESP) && err_q;
  assign apbs_prdata  = prdata_q;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Directed bench for apb_to_ahbl: APB requester driver, scripted AHB-Lite slave, per-cycle checks.
module tb_apb_to_ahbl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hready, hresp;
  logic [31:0] hrdata, hwdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_to_ahbl #(.W_ADDR(32), .HPROT_VAL(4'b0011)) dut (
    .clk             (clk),
    .rst             (rst),
    .apbs_psel       (psel),
    .apbs_penable    (penable),
    .apbs_pwrite     (pwrite),
    .apbs_paddr      (paddr),
    .apbs_pwdata     (pwdata),
`ifdef APB_TO_AHBL_PSTRB_EN
    .apbs_pstrb      (pstrb),
`endif
    .apbs_prdata     (prdata),
    .apbs_pready     (pready),
    .apbs_pslverr    (pslverr),
    .ahblm_haddr     (haddr),
    .ahblm_hwrite    (hwrite),
    .ahblm_htrans    (htrans),
    .ahblm_hsize     (hsize),
    .ahblm_hburst    (hburst),
    .ahblm_hprot     (hprot),
    .ahblm_hmastlock (hmastlock),
    .ahblm_hready    (hready),
    .ahblm_hresp     (hresp),
    .ahblm_hrdata    (hrdata),
    .ahblm_hwdata    (hwdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One APB access against a scripted slave; lat counts cycles from the first penable cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic err,
                          input logic [31:0] rdata, input logic [31:0] exp_haddr,
                          input logic [2:0] exp_size, input int exp_ahb, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_prdata);
    int lat, dcnt, fin, nonseq_cnt;
    bit start_data, done;
    fin = err ? waits + 1 : waits;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    check_val("setup_no_xfer", 32'(htrans), 32'h0);
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; dcnt = -1; start_data = 1'b0; done = 1'b0; nonseq_cnt = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("pslverr", 32'(pslverr), 32'(exp_err));
        check_val("prdata", prdata, exp_prdata);
        check_val("resp_htrans", 32'(htrans), 32'h0);
      end else begin
        check_val("pslverr_low", 32'(pslverr), 32'h0);
        if (htrans == 2'b10) begin
          nonseq_cnt++;
          start_data = 1'b1;
          check_val("haddr", haddr, exp_haddr);
          check_val("hwrite", 32'(hwrite), 32'(wr));
          check_val("hsize", 32'(hsize), 32'(exp_size));
        end else begin
          check_val("htrans_idle", 32'(htrans), 32'h0);
          if (dcnt >= 0 && wr) check_val("hwdata", hwdata, wdata);
        end
      end
      @(posedge clk); #1;
      if (!done) begin
        lat++;
        if (start_data) begin
          dcnt = 0;
          start_data = 1'b0;
        end else if (dcnt >= 0) begin
          dcnt++;
        end
        if (dcnt > fin) dcnt = -1;
        if (dcnt >= 0) begin
          hready = (dcnt == fin);
          hresp  = err && (dcnt >= waits);
          hrdata = (dcnt == fin) ? rdata : 32'hDEADBEEF;
        end else begin
          hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        end
      end
    end
    if (!done) check_val("pready_timeout", 32'(lat), 32'(exp_lat));
    check_val("nonseq_count", 32'(nonseq_cnt), 32'(exp_ahb));
    psel = 1'b0; penable = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    @(negedge clk);
    check_val("pready_one_cycle", 32'(pready), 32'h0);
    check_val("pslverr_after", 32'(pslverr), 32'h0);
    check_val("prdata_hold", prdata, exp_prdata);
    $display("xfer %s addr=0x%08h lat=%0d pslverr=%0d prdata=0x%08h", wr ? "WR" : "RD",
             addr, lat, exp_err, prdata);
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    pstrb = 4'hF; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_htrans", 32'(htrans), 32'h0);
    check_val("rst_haddr", haddr, 32'h0);
    check_val("rst_hwrite", 32'(hwrite), 32'h0);
    check_val("rst_hwdata", hwdata, 32'h0);
    check_val("rst_prdata", prdata, 32'h0);
    check_val("rst_pready", 32'(pready), 32'h0);
    check_val("rst_pslverr", 32'(pslverr), 32'h0);
    check_val("hburst", 32'(hburst), 32'h0);
    check_val("hprot", 32'(hprot), 32'h3);
    check_val("hmastlock", 32'(hmastlock), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // psel held without penable must never start a transfer
    psel = 1'b1; paddr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("psel_only_htrans", 32'(htrans), 32'h0);
      check_val("psel_only_pready", 32'(pready), 32'h0);
      @(posedge clk); #1;
    end
    psel = 1'b0;

    apb_xfer(1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0,
             32'h4000_0010, 3'd2, 1, 3, 1'b0, 32'h0);
    apb_xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678,
             32'h0000_0020, 3'd2, 1, 6, 1'b0, 32'h1234_5678);
    apb_xfer(1'b0, 32'h0000_0024, 32'h0, 4'hF, 0, 1'b1, 32'hBAD0_BAD0,
             32'h0000_0024, 3'd2, 1, 4, 1'b1, 32'hBAD0_BAD0);
    apb_xfer(1'b0, 32'h0000_0033, 32'h0, 4'hF, 1, 1'b0, 32'hA5A5_0F0F,
             32'h0000_0030, 3'd2, 1, 4, 1'b0, 32'hA5A5_0F0F);
    apb_xfer(1'b1, 32'h0000_0104, 32'h1122_3344, 4'hF, 2, 1'b0, 32'h0,
             32'h0000_0104, 3'd2, 1, 5, 1'b0, 32'h0);

    // reset while the bridge is waiting in the data phase
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h80;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_mid_nonseq", 32'(htrans), 32'h2);
    @(posedge clk); #1;
    hready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_mid_htrans", 32'(htrans), 32'h0);
    check_val("rst_mid_pready", 32'(pready), 32'h0);
    check_val("rst_mid_haddr", haddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("post_rst_pready", 32'(pready), 32'h0);
      check_val("post_rst_htrans", 32'(htrans), 32'h0);
    end
    $display("xfer RD addr=0x00000080 abandoned by reset");
    apb_xfer(1'b0, 32'h0000_0080, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_CAFE,
             32'h0000_0080, 3'd2, 1, 3, 1'b0, 32'h0BAD_CAFE);

`ifdef APB_TO_AHBL_PSTRB_EN
    apb_xfer(1'b1, 32'h0000_0100, 32'h00AB_0000, 4'b0100, 0, 1'b0, 32'h0,
             32'h0000_0102, 3'd0, 1, 3, 1'b0, 32'h0);
    apb_xfer(1'b1, 32'h0000_0200, 32'hDEAD_0000, 4'b1100, 0, 1'b0, 32'h0,
             32'h0000_0202, 3'd1, 1, 3, 1'b0, 32'h0);
    apb_xfer(1'b1, 32'h0000_0100, 32'h0000_0055, 4'b0101, 0, 1'b0, 32'h0,
             32'h0, 3'd2, 0, 1, 1'b1, 32'h0);
    apb_xfer(1'b0, 32'h0000_0040, 32'h0, 4'b0001, 0, 1'b0, 32'h7777_8888,
             32'h0000_0040, 3'd2, 1, 3, 1'b0, 32'h7777_8888);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
